// File: rtl/timer_irq.sv
// Memory-mapped timer with 16-bit prescaler, compare match, one-shot or
// auto-reload mode, and a level interrupt, on a BRAM-style registered read port.
module timer_irq #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        w_enable_i,
   input  logic [31:0] w_addr_i,
   input  logic [31:0] w_data_i,
   input  logic        r_enable_i,
   input  logic [31:0] r_addr_i,
   output logic [31:0] r_data_o,
   output logic        irq_o
);

   localparam logic [5:0] OFS_CTRL   = 6'h00;
   localparam logic [5:0] OFS_STATUS = 6'h01;
   localparam logic [5:0] OFS_COUNT  = 6'h02;
   localparam logic [5:0] OFS_CMP    = 6'h03;
   localparam logic [5:0] OFS_PRESC  = 6'h04;

   logic        en, ie, auto_rl, pend;
   logic [31:0] count, cmp;
   logic [15:0] presc, pcnt;
   logic [31:0] r_data;

   logic        w_hit, r_hit;
   logic        wr_ctrl, wr_status, wr_count, wr_cmp, wr_presc;
   logic        tick, en_kill, cnt_tick, match;
   logic [31:0] rd_mux;
   logic        unused_bits;

   assign w_hit     = w_enable_i && (w_addr_i[31:8] == BASE_ADDR[31:8]);
   assign r_hit     = r_addr_i[31:8] == BASE_ADDR[31:8];
   assign wr_ctrl   = w_hit && (w_addr_i[7:2] == OFS_CTRL);
   assign wr_status = w_hit && (w_addr_i[7:2] == OFS_STATUS);
   assign wr_count  = w_hit && (w_addr_i[7:2] == OFS_COUNT);
   assign wr_cmp    = w_hit && (w_addr_i[7:2] == OFS_CMP);
   assign wr_presc  = w_hit && (w_addr_i[7:2] == OFS_PRESC);

   // A software COUNT write or an EN-clearing CTRL write pre-empts the tick.
   assign tick     = en && (pcnt == presc);
   assign en_kill  = wr_ctrl && !w_data_i[0];
   assign cnt_tick = tick && !en_kill && !wr_count;
   assign match    = cnt_tick && (count == cmp);

   assign unused_bits = ^{w_addr_i[1:0], r_addr_i[1:0]};

   always_comb begin
      rd_mux = 32'd0;
      case (r_addr_i[7:2])
         OFS_CTRL:   rd_mux = {29'd0, auto_rl, ie, en};
         OFS_STATUS: rd_mux = {31'd0, pend};
         OFS_COUNT:  rd_mux = count;
         OFS_CMP:    rd_mux = cmp;
         OFS_PRESC:  rd_mux = {16'd0, presc};
         default:    rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         auto_rl <= 1'b0;
         pend    <= 1'b0;
         count   <= 32'd0;
         cmp     <= 32'hFFFF_FFFF;
         presc   <= 16'd0;
         pcnt    <= 16'd0;
         r_data  <= 32'd0;
      end else begin
         if (wr_ctrl)
            {auto_rl, ie, en} <= w_data_i[2:0];
         else if (match && !auto_rl)
            en <= 1'b0;

         // A new match outranks a simultaneous W1C.
         if (match)
            pend <= 1'b1;
         else if (wr_status && w_data_i[0])
            pend <= 1'b0;

         if (wr_count)
            count <= w_data_i;
         else if (match)
            count <= auto_rl ? 32'd0 : count;
         else if (cnt_tick)
            count <= count + 32'd1;

         if (wr_cmp)
            cmp <= w_data_i;
         if (wr_presc)
            presc <= w_data_i[15:0];

         if (!en || wr_presc || wr_ctrl || tick)
            pcnt <= 16'd0;
         else
            pcnt <= pcnt + 16'd1;

         // Registered read returns pre-write state.
         if (r_enable_i)
            r_data <= r_hit ? rd_mux : 32'd0;
      end
   end

   assign r_data_o = r_data;
   assign irq_o    = pend & ie;

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: register access, prescaled counting, match
// handling, write/tick races and reset behaviour.
module tb_timer_irq;

   localparam logic [31:0] BASE   = 32'h1000_0000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_STAT = BASE + 32'h04;
   localparam logic [31:0] A_CNT  = BASE + 32'h08;
   localparam logic [31:0] A_CMP  = BASE + 32'h0C;
   localparam logic [31:0] A_PRSC = BASE + 32'h10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        w_enable = 1'b0;
   logic [31:0] w_addr = 32'd0;
   logic [31:0] w_data = 32'd0;
   logic        r_enable = 1'b0;
   logic [31:0] r_addr = 32'd0;
   logic [31:0] r_data;
   logic        irq;

   int checks = 0;
   int failures = 0;

   timer_irq #(.BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .w_enable_i (w_enable),
      .w_addr_i   (w_addr),
      .w_data_i   (w_data),
      .r_enable_i (r_enable),
      .r_addr_i   (r_addr),
      .r_data_o   (r_data),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      w_enable = 1'b1;
      w_addr   = addr;
      w_data   = data;
      step();
      w_enable = 1'b0;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      r_enable = 1'b1;
      r_addr   = addr;
      step();
      r_enable = 1'b0;
      data     = r_data;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   logic [31:0] d;

   initial begin
      // Power-on reset
      do_reset();
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_rdata", r_data, 32'd0);
      rd(A_CMP, d);   check("rst_cmp", d, 32'hFFFF_FFFF);
      rd(A_CTRL, d);  check("rst_ctrl", d, 32'd0);
      rd(A_CNT, d);   check("rst_count", d, 32'd0);

      // Free-running one-shot: PRESC=0, CMP=5, CTRL=EN|IE
      wr(A_CMP, 32'd5);
      r_enable = 1'b1;
      r_addr   = A_CNT;
      wr(A_CTRL, 32'd3);
      step();
      check("fr_first", r_data, 32'd0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check("fr_count", r_data, i);
      end
      check("fr_irq", {31'd0, irq}, 32'd1);
      r_addr = A_STAT; step(); check("fr_pend", r_data, 32'd1);
      r_addr = A_CTRL; step(); check("fr_en_off", r_data, 32'd2);
      r_addr = A_CNT;  step(); check("fr_hold", r_data, 32'd5);
      step();                  check("fr_hold2", r_data, 32'd5);
      r_enable = 1'b0;

      // Prescale 3, CMP=2, auto-reload, W1C races, reset mid-run
      do_reset();
      wr(A_PRSC, 32'd3);
      wr(A_CMP, 32'd2);
      r_enable = 1'b1;
      r_addr   = A_CNT;
      wr(A_CTRL, 32'd7);
      for (int k = 1; k <= 37; k++) begin
         step();
         case (k)
            3:  check("ps_c0", r_data, 32'd0);
            5:  check("ps_c1", r_data, 32'd1);
            9:  check("ps_c2", r_data, 32'd2);
            11: check("ps_irq_lo", {31'd0, irq}, 32'd0);
            12: check("ps_irq_hi", {31'd0, irq}, 32'd1);
            13: begin
               check("ps_reload", r_data, 32'd0);
               w_enable = 1'b1; w_addr = A_STAT; w_data = 32'd1;
            end
            14: begin
               w_enable = 1'b0;
               check("w1c_clear", {31'd0, irq}, 32'd0);
            end
            23: begin
               w_enable = 1'b1; w_addr = A_STAT; w_data = 32'd1;
            end
            24: check("w1c_race_set", {31'd0, irq}, 32'd1);
            25: begin
               w_enable = 1'b0;
               check("w1c_late", {31'd0, irq}, 32'd0);
            end
            35: check("ps_irq_lo2", {31'd0, irq}, 32'd0);
            36: begin
               check("ps_irq_hi2", {31'd0, irq}, 32'd1);
               rst_n = 1'b0;
               w_enable = 1'b1; w_addr = A_CMP; w_data = 32'd0;
            end
            37: begin
               rst_n = 1'b1;
               w_enable = 1'b0;
               check("mid_rst_irq", {31'd0, irq}, 32'd0);
               check("mid_rst_rdata", r_data, 32'd0);
            end
            default: ;
         endcase
      end
      r_enable = 1'b0;
      rd(A_CTRL, d); check("mr_ctrl", d, 32'd0);
      rd(A_STAT, d); check("mr_stat", d, 32'd0);
      rd(A_CMP, d);  check("mr_cmp", d, 32'hFFFF_FFFF);
      rd(A_PRSC, d); check("mr_presc", d, 32'd0);
      step(); step(); step();
      rd(A_CNT, d);  check("mr_count_frozen", d, 32'd0);

      // Wrap, COUNT-write priority, EN-clear priority
      do_reset();
      wr(A_CNT, 32'hFFFF_FFFF);
      wr(A_CMP, 32'd3);
      r_enable = 1'b1;
      r_addr   = A_CNT;
      wr(A_CTRL, 32'd3);
      for (int k = 1; k <= 8; k++) begin
         step();
         case (k)
            2: begin
               check("wrap_zero", r_data, 32'd0);
               check("wrap_no_irq", {31'd0, irq}, 32'd0);
               w_enable = 1'b1; w_addr = A_CNT; w_data = 32'd7;
            end
            3: w_enable = 1'b0;
            4: check("cnt_wr_wins", r_data, 32'd7);
            5: begin
               check("cnt_runs", r_data, 32'd8);
               w_enable = 1'b1; w_addr = A_CTRL; w_data = 32'd0;
            end
            6: w_enable = 1'b0;
            7: check("en_kill", r_data, 32'd9);
            8: check("en_kill_hold", r_data, 32'd9);
            default: ;
         endcase
      end
      r_enable = 1'b0;

      // Read decode, latency, hold, and read-during-write
      do_reset();
      rd(A_CMP, d);               check("rd_cmp", d, 32'hFFFF_FFFF);
      rd(32'h2000_000C, d);       check("rd_outside", d, 32'd0);
      rd(BASE + 32'h0F, d);       check("rd_lowbits", d, 32'hFFFF_FFFF);
      rd(BASE + 32'h40, d);       check("rd_unmapped", d, 32'd0);
      rd(A_CMP, d);
      r_addr = A_CTRL;
      step(); step();
      check("rd_hold", r_data, 32'hFFFF_FFFF);
      wr(32'h2000_000C, 32'd0);
      rd(A_CMP, d);               check("wr_outside", d, 32'hFFFF_FFFF);
      r_enable = 1'b1; r_addr = A_CMP;
      wr(A_CMP, 32'd5);
      r_enable = 1'b0;
      check("rw_prewrite", r_data, 32'hFFFF_FFFF);
      rd(A_CMP, d);               check("rw_postwrite", d, 32'd5);
      wr(A_PRSC, 32'hABCD_1234);
      rd(A_PRSC, d);              check("presc_mask", d, 32'h0000_1234);
      wr(A_CTRL, 32'hFFFF_FFFE);
      rd(A_CTRL, d);              check("ctrl_mask", d, 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning base of the 256-byte register window (bits [7:0] of the parameter are ignored).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port w_enable_i  input  1  data-port write strobe, driven by the core's mem_w_enable_o.
REQ-005 SHALL have port w_addr_i  input  32  write byte address.
REQ-006 SHALL have port w_data_i  input  32  write data (word writes only).
REQ-007 SHALL have port r_enable_i  input  1  data-port read strobe, driven by the core's mem_r_enable_o and issued in the EX stage.
REQ-008 SHALL have port r_addr_i  input  32  read byte address.
REQ-009 SHALL have port r_data_o  output  32  registered read data, valid exactly 1 cycle after the read strobe (BRAM-compatible).
REQ-010 SHALL have port irq_o  output  1  level interrupt request to the core's irq_req_i.

Function
REQ-011 SHALL decode a hit when addr[31:8] == BASE_ADDR[31:8]; the register offset SHALL be addr[7:0], with addr[1:0] ignored.
REQ-012 SHALL implement CTRL at 0x00 (RW): bit0 EN, bit1 IE, bit2 AUTO (auto-reload); bits [31:3] SHALL read as 0.
REQ-013 SHALL implement STATUS at 0x04: bit0 PEND, where writing 1 clears it and writing 0 has no effect; all other bits SHALL read as 0.
REQ-014 SHALL implement COUNT at 0x08 (RW, 32 bits), CMP at 0x0C (RW, 32 bits) and PRESC at 0x10 (RW, bits [15:0]; bits [31:16] read as 0).
REQ-015 SHALL ignore writes to unmapped offsets or outside the window, and SHALL return 0 for reads of them.
REQ-016 Prescaler: a 16-bit counter pcnt SHALL run only while EN=1.
    - If pcnt == PRESC: the cycle SHALL be a tick and pcnt SHALL be set to 0.
    - Otherwise pcnt SHALL increment.
    - Resulting tick rate: one tick every PRESC+1 cycles.
REQ-017 pcnt SHALL be cleared whenever EN=0, or when PRESC or CTRL is written.
REQ-018 On a tick with COUNT != CMP, COUNT SHALL increment, wrapping from 32'hFFFF_FFFF to 0 with no flag.
REQ-019 On a tick with COUNT == CMP:
    - PEND SHALL be set.
    - If AUTO=1, COUNT SHALL become 0.
    - If AUTO=0, COUNT SHALL hold and EN SHALL be cleared (one-shot).
REQ-020 irq_o SHALL equal PEND & IE, decoded from registered state only, with no combinational path from any bus input.
REQ-021 Read path: when r_enable_i is asserted with a hit, r_data_o SHALL be loaded the next cycle with the register value as it was before that edge.
    - When there is no hit, r_data_o SHALL load 0 the next cycle.
    - When r_enable_i=0, r_data_o SHALL hold its previous value.
REQ-022 A read and a write in the same cycle SHALL both be serviced; the read SHALL return the pre-write value.
REQ-023 A software write to COUNT in a tick cycle SHALL win: COUNT takes the written value, with no increment and no match evaluation that cycle.
REQ-024 A write clearing EN in a tick cycle SHALL win: no increment and no PEND set.
REQ-025 A W1C of PEND in the same cycle as a new match SHALL leave PEND=1 (set wins).
REQ-026 A write to CMP takes effect on the next tick; a match SHALL use the CMP value registered before that tick's edge.

Reset
REQ-027 With rst_n=0 at a clock edge, the following SHALL all be 0 after that edge regardless of any bus activity that cycle: CTRL, PEND, COUNT, PRESC, pcnt, r_data_o, irq_o.
    - CMP SHALL reset to 32'hFFFF_FFFF.
REQ-028 A reset asserted mid-count or mid-read SHALL discard the pending read data and the count; after reset deassertion, no tick SHALL occur until EN is written to 1.

Verification
REQ-029 Free run: PRESC=0, CMP=5, CTRL=3'b011 -> COUNT reads 1,2,3,4,5 on successive cycles; PEND=1 and irq_o=1 on the tick after COUNT=5; COUNT holds at 5; EN reads 0.
REQ-030 Prescale + auto-reload: PRESC=3, CMP=2, CTRL=3'b111 -> a tick every 4 cycles; COUNT sequence 0,1,2,0; PEND set every 12 cycles.
REQ-031 W1C race: write STATUS=1 in the exact cycle of a match -> PEND stays 1. The same write one cycle later -> PEND=0 and irq_o=0 the following cycle.
REQ-032 Read latency/decode: r_enable_i=1 with r_addr_i=BASE+0x0C -> r_data_o=32'hFFFF_FFFF on the next cycle. Read of BASE+0x40 -> 0. Read of 0x2000_0000 -> 0. Holding r_enable_i=0 -> r_data_o unchanged.
REQ-033 Wrap and write-priority: COUNT=32'hFFFF_FFFF, CMP=3, EN=1, PRESC=0 -> COUNT becomes 0 with no PEND. A COUNT write of 7 coinciding with a tick -> COUNT reads 7.
REQ-034 Reset mid-operation: assert rst_n=0 for one edge while running with PEND=1 -> all registers at reset values (CMP=32'hFFFF_FFFF), irq_o=0, COUNT frozen at 0.
